// File: rtl/led_scan_scheduler_if.sv
// Write/swap handshake between the display-content logic and led_scan_scheduler.
// The content side uses the master modport; the scheduler uses the slave modport.
interface led_scan_scheduler_if;
    logic        i_wr_valid;
    logic [1:0]  i_wr_col;
    logic [31:0] i_wr_levels;
    logic        o_wr_ready;
    logic        i_swap_req;
    logic        o_swap_done;

    modport master (
        output i_wr_valid, i_wr_col, i_wr_levels, i_swap_req,
        input  o_wr_ready, o_swap_done
    );

    modport slave (
        input  i_wr_valid, i_wr_col, i_wr_levels, i_swap_req,
        output o_wr_ready, o_swap_done
    );
endinterface

// File: rtl/led_scan_scheduler.sv
// 4x8 multiplexed LED matrix scanner with a double-buffered frame and 16-step PWM per column.
// Optional macro LEDSCAN_GAMMA_EN: write data passes through a gamma LUT before storage.
module led_scan_scheduler #(
    parameter int unsigned PRESCALE     = 1024,
    parameter int unsigned BLANK_CYCLES = 8
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    led_scan_scheduler_if.slave  wr_bus,
    output logic                 o_frame_start,
    output logic [3:0]           o_column_enable,
    output logic [7:0]           o_row_enable
);

    localparam int unsigned PreW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned BlankW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [PreW-1:0]   PreMax   = PreW'(PRESCALE - 1);
    localparam logic [BlankW-1:0] BlankMax = BlankW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    typedef enum logic {StBlank, StDrive} state_e;
    // With no blanking the scanner never visits BLANK, so it starts straight in DRIVE.
    localparam state_e StInit = (BLANK_CYCLES == 0) ? StDrive : StBlank;

    function automatic logic [31:0] map_levels(input logic [31:0] lv);
        logic [31:0] res;
        res = lv;
`ifdef LEDSCAN_GAMMA_EN
        for (int r = 0; r < 8; r++) begin
            case (lv[4*r +: 4])
                4'd0, 4'd1, 4'd2:    res[4*r +: 4] = 4'd0;
                4'd3, 4'd4, 4'd5:    res[4*r +: 4] = 4'd1;
                4'd6, 4'd7:          res[4*r +: 4] = 4'd2;
                4'd8:                res[4*r +: 4] = 4'd3;
                4'd9:                res[4*r +: 4] = 4'd4;
                4'd10:               res[4*r +: 4] = 4'd5;
                4'd11:               res[4*r +: 4] = 4'd6;
                4'd12:               res[4*r +: 4] = 4'd8;
                4'd13:               res[4*r +: 4] = 4'd10;
                4'd14:               res[4*r +: 4] = 4'd12;
                default:             res[4*r +: 4] = 4'd15;
            endcase
        end
`endif
        return res;
    endfunction

    state_e              st_q, st_d;
    logic [1:0]          col_q, col_d;
    logic [3:0]          step_q, step_d;
    logic [PreW-1:0]     pre_q, pre_d;
    logic [BlankW-1:0]   blank_q, blank_d;
    logic [3:0][31:0]    front_q, back_q;
    logic                pending_q, pending_d;
    logic                swap_done_q;
    logic                frame_start_q, frame_start_d;
    logic [3:0]          col_en_q, col_en_d;
    logic [7:0]          row_en_q, row_en_d;
    logic                drive_last, boundary, wr_fire;

    assign wr_bus.o_wr_ready  = ~pending_q;
    assign wr_bus.o_swap_done = swap_done_q;
    assign o_frame_start      = frame_start_q;
    assign o_column_enable    = col_en_q;
    assign o_row_enable       = row_en_q;

    always_comb begin
        st_d       = st_q;
        col_d      = col_q;
        step_d     = step_q;
        pre_d      = pre_q;
        blank_d    = blank_q;
        drive_last = 1'b0;
        case (st_q)
            StBlank: begin
                if (blank_q == BlankMax) begin
                    st_d    = StDrive;
                    blank_d = '0;
                end else begin
                    blank_d = blank_q + 1'b1;
                end
            end
            StDrive: begin
                if (pre_q == PreMax) begin
                    pre_d  = '0;
                    step_d = step_q + 4'd1;
                    if (step_q == 4'hF) begin
                        drive_last = 1'b1;
                        col_d      = col_q + 2'd1;
                        st_d       = (BLANK_CYCLES == 0) ? StDrive : StBlank;
                    end
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end
        endcase
    end

    assign boundary  = drive_last && (col_q == 2'd3);
    assign wr_fire   = wr_bus.i_wr_valid && !pending_q;
    // A request in the boundary cycle itself survives into the next frame.
    assign pending_d = (pending_q && !boundary) || wr_bus.i_swap_req;

    // Pin values for the current scan position; registered so pins never see input paths.
    always_comb begin
        col_en_d = 4'hF;
        row_en_d = 8'hFF;
        if (st_q == StDrive) begin
            col_en_d[col_q] = 1'b0;
            for (int r = 0; r < 8; r++) begin
                row_en_d[r] = ~(front_q[col_q][4*r +: 4] > step_q);
            end
        end
        if (st_q == StBlank) begin
            frame_start_d = (col_q == 2'd0) && (blank_q == '0);
        end else begin
            frame_start_d = (BLANK_CYCLES == 0) && (col_q == 2'd0) &&
                            (step_q == 4'd0) && (pre_q == '0);
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            st_q          <= StInit;
            col_q         <= 2'd0;
            step_q        <= 4'd0;
            pre_q         <= '0;
            blank_q       <= '0;
            front_q       <= '0;
            back_q        <= '0;
            pending_q     <= 1'b0;
            swap_done_q   <= 1'b0;
            frame_start_q <= 1'b0;
            col_en_q      <= 4'hF;
            row_en_q      <= 8'hFF;
        end else begin
            st_q          <= st_d;
            col_q         <= col_d;
            step_q        <= step_d;
            pre_q         <= pre_d;
            blank_q       <= blank_d;
            pending_q     <= pending_d;
            swap_done_q   <= boundary && pending_q;
            frame_start_q <= frame_start_d;
            col_en_q      <= col_en_d;
            row_en_q      <= row_en_d;
            if (wr_fire) begin
                back_q[wr_bus.i_wr_col] <= map_levels(wr_bus.i_wr_levels);
            end
            if (boundary && pending_q) begin
                front_q <= back_q;
            end
        end
    end

endmodule

// File: tb/tb_led_scan_scheduler.sv
// Randomized + directed bench for led_scan_scheduler against a frame-position reference model.
// Model honours LEDSCAN_GAMMA_EN the same way the build does.
module tb_led_scan_scheduler;

    localparam int unsigned P  = 2;
    localparam int unsigned B1 = 2;
    localparam int unsigned B2 = 0;
    localparam int unsigned F1 = 4 * (B1 + 16 * P);
    localparam int unsigned F2 = 4 * (B2 + 16 * P);
    localparam int Lut [16] = '{0, 0, 0, 1, 1, 1, 2, 2, 3, 4, 5, 6, 8, 10, 12, 15};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    led_scan_scheduler_if bus1 ();
    led_scan_scheduler_if bus2 ();

    logic       fs1, fs2;
    logic [3:0] ce1, ce2;
    logic [7:0] re1, re2;

    led_scan_scheduler #(.PRESCALE(P), .BLANK_CYCLES(B1)) dut1 (
        .i_clock         (clk),
        .i_reset_n       (rst_n),
        .wr_bus          (bus1),
        .o_frame_start   (fs1),
        .o_column_enable (ce1),
        .o_row_enable    (re1)
    );

    led_scan_scheduler #(.PRESCALE(P), .BLANK_CYCLES(B2)) dut2 (
        .i_clock         (clk),
        .i_reset_n       (rst_n),
        .wr_bus          (bus2),
        .o_frame_start   (fs2),
        .o_column_enable (ce2),
        .o_row_enable    (re2)
    );

    int          checks = 0;
    int          failures = 0;
    int unsigned n;
    logic [31:0] front_m [4];
    logic [31:0] back_m [4];
    bit          pending_m;
    int          sd_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int col_of(input int unsigned pos, input int unsigned blank);
        return int'((pos % (4 * (blank + 16 * P))) / (blank + 16 * P));
    endfunction

    // -1 while blanking, else PWM step 0..15
    function automatic int step_of(input int unsigned pos, input int unsigned blank);
        int unsigned off;
        off = pos % (blank + 16 * P);
        if (off < blank) return -1;
        return int'((off - blank) / P);
    endfunction

    function automatic logic [3:0] exp_col(input int unsigned pos, input int unsigned blank);
        logic [3:0] v;
        v = 4'hF;
        if (step_of(pos, blank) >= 0) v[col_of(pos, blank)] = 1'b0;
        return v;
    endfunction

    function automatic logic [7:0] exp_row(input logic [31:0] word, input int s);
        logic [7:0] v;
        v = 8'hFF;
        if (s >= 0) begin
            for (int r = 0; r < 8; r++) v[r] = !(int'(word[4*r +: 4]) > s);
        end
        return v;
    endfunction

    function automatic logic [31:0] gamma(input logic [31:0] lv);
        logic [31:0] res;
        res = lv;
`ifdef LEDSCAN_GAMMA_EN
        for (int r = 0; r < 8; r++) res[4*r +: 4] = 4'(Lut[int'(lv[4*r +: 4])]);
`endif
        return res;
    endfunction

    task automatic model_reset();
        n = 0;
        pending_m = 1'b0;
        for (int i = 0; i < 4; i++) begin
            front_m[i] = 32'h0;
            back_m[i]  = 32'h0;
        end
    endtask

    task automatic check_reset_pins(input string tag);
        chk({tag, "_ce1"}, 32'(ce1), 32'hF);
        chk({tag, "_re1"}, 32'(re1), 32'hFF);
        chk({tag, "_ce2"}, 32'(ce2), 32'hF);
        chk({tag, "_re2"}, 32'(re2), 32'hFF);
        chk({tag, "_rdy"}, 32'(bus1.o_wr_ready), 32'h1);
        chk({tag, "_sd"},  32'(bus1.o_swap_done), 32'h0);
        chk({tag, "_fs"},  32'(fs1), 32'h0);
    endtask

    // Drive one cycle of inputs; check the outputs that the following edge produces.
    task automatic step(input bit v, input logic [1:0] c, input logic [31:0] lv, input bit req);
        logic [3:0] e_ce1, e_ce2;
        logic [7:0] e_re1, e_re2;
        bit         e_fs1, e_fs2, e_sd, e_rdy, boundary;
        bus1.i_wr_valid  = v;
        bus1.i_wr_col    = c;
        bus1.i_wr_levels = lv;
        bus1.i_swap_req  = req;
        e_ce1 = exp_col(n, B1);
        e_re1 = exp_row(front_m[col_of(n, B1)], step_of(n, B1));
        e_fs1 = (n % F1) == 0;
        e_ce2 = exp_col(n, B2);
        e_re2 = exp_row(32'h0, step_of(n, B2));
        e_fs2 = (n % F2) == 0;
        boundary = (n % F1) == F1 - 1;
        e_sd = boundary && pending_m;
        if (v && !pending_m) back_m[c] = gamma(lv);
        if (e_sd) for (int i = 0; i < 4; i++) front_m[i] = back_m[i];
        pending_m = (pending_m && !boundary) || req;
        e_rdy = !pending_m;
        @(posedge clk);
        @(negedge clk);
        bus1.i_wr_valid = 1'b0;
        bus1.i_swap_req = 1'b0;
        n++;
        chk("col1", 32'(ce1), 32'(e_ce1));
        chk("row1", 32'(re1), 32'(e_re1));
        chk("fs1",  32'(fs1), 32'(e_fs1));
        chk("sd1",  32'(bus1.o_swap_done), 32'(e_sd));
        chk("rdy1", 32'(bus1.o_wr_ready), 32'(e_rdy));
        chk("col2", 32'(ce2), 32'(e_ce2));
        chk("row2", 32'(re2), 32'(e_re2));
        chk("fs2",  32'(fs2), 32'(e_fs2));
        if (bus1.o_swap_done) sd_seen++;
    endtask

    task automatic idle();
        step(1'b0, 2'd0, 32'h0, 1'b0);
    endtask

    initial begin
        bus1.i_wr_valid = 1'b0;  bus1.i_wr_col = 2'd0;  bus1.i_wr_levels = 32'h0;
        bus1.i_swap_req = 1'b0;
        bus2.i_wr_valid = 1'b0;  bus2.i_wr_col = 2'd0;  bus2.i_wr_levels = 32'h0;
        bus2.i_swap_req = 1'b0;
        sd_seen = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_pins("rst");
        rst_n = 1'b1;

        repeat (F1 + 4) idle();

        // Column 1: row 0 level 8, row 7 level 15, then request a swap
        step(1'b1, 2'd1, 32'hF000_0008, 1'b0);
        step(1'b0, 2'd0, 32'h0, 1'b1);
        repeat (2 * F1) idle();

        // Write + swap together, repeated request, then a dropped write
        sd_seen = 0;
        step(1'b1, 2'd2, 32'h9ABC_DEF1, 1'b1);
        step(1'b0, 2'd0, 32'h0, 1'b1);
        step(1'b1, 2'd3, 32'hFFFF_FFFF, 1'b0);
        repeat (2 * F1) idle();
        chk("one_swap", 32'(sd_seen), 32'd1);

        // Request landing exactly in the boundary cycle
        while ((n % F1) != F1 - 1) idle();
        step(1'b1, 2'd0, 32'h7654_3210, 1'b1);
        repeat (2 * F1 + 2) idle();

        repeat (700) begin
            step($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)), $urandom,
                 $urandom_range(0, 39) == 0);
        end
        repeat (F1 + 2) idle();

        // Asynchronous reset in the middle of column 1 DRIVE
        while ((n % F1) != 50) idle();
        rst_n = 1'b0;
        #1;
        check_reset_pins("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (F1 + 4) idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
